hack_data_bus: RTL and testbench

- Data-memory subsystem directly downstream of the Hack CPU. Consumes the CPU's addressM, outM and writeM, and returns inM.
- Decodes the Hack memory map into three regions: 16K-word data RAM, 8K-word screen, and the keyboard register.
- Every screen write is mirrored into a local shadow memory and queued in a small FIFO. The FIFO drains to the display controller over a valid/ready handshake.
- Keyboard scancodes arrive on a strobed input and are latched for CPU reads.

---
 rtl/hack_data_bus.sv | 135 +++++++++++++
 tb/tb_hack_data_bus.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_data_bus.sv
// Hack data-memory subsystem: RAM, screen shadow with a display-write queue,
// and the keyboard register, all decoded from the CPU's addressM.
module hack_data_bus #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [14:0]      addressM,
  input  logic [15:0]      outM,
  input  logic             writeM,
  output logic [15:0]      inM,
  output logic             scr_valid,
  input  logic             scr_ready,
  output logic [12:0]      scr_addr,
  output logic [15:0]      scr_data,
  input  logic             kbd_valid,
  input  logic [15:0]      kbd_code,
  output logic             ovf_flag,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [15:0] ram_mem    [0:16383];
  logic [15:0] screen_mem [0:8191];
  logic [12:0] fifo_addr_mem [0:FIFO_DEPTH-1];
  logic [15:0] fifo_data_mem [0:FIFO_DEPTH-1];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      kbd_reg;
  logic             ovf_reg;

  logic is_ram;
  logic is_scr;
  logic is_kbd;
  logic scr_write;
  logic fifo_full;
  logic push;
  logic pop;
  logic drop;

  assign is_ram = (addressM[14] == 1'b0);
  assign is_scr = (addressM[14:13] == 2'b10);
  assign is_kbd = (addressM == 15'h6000);

  assign scr_write = writeM && is_scr;
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));

  // Handshake: scr_valid/scr_addr/scr_data describe the head entry and hold
  // steady until the display raises scr_ready; a transfer happens on any
  // rising edge where both scr_valid and scr_ready are high. A full queue can
  // still accept a write in the cycle its head is being taken.
  assign pop  = scr_valid && scr_ready;
  assign push = scr_write && (!fifo_full || pop);
  assign drop = scr_write && fifo_full && !pop;

  // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
  always_comb begin
    inM = 16'h0000;
    if (is_ram) begin
      inM = ram_mem[addressM[13:0]];
    end else if (is_scr) begin
      inM = screen_mem[addressM[12:0]];
    end else if (is_kbd) begin
      inM = kbd_reg;
    end
  end

  // Storage arrays intentionally survive reset.
  always_ff @(posedge clk) begin
    if (writeM && is_ram) begin
      ram_mem[addressM[13:0]] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (scr_write) begin
      screen_mem[addressM[12:0]] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr] <= addressM[12:0];
      fifo_data_mem[wr_ptr] <= outM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_reg <= 16'h0000;
    end else if (kbd_valid) begin
      kbd_reg <= kbd_code;
    end
  end

  // Head fields are forced to zero while empty so a flushed queue reads clean.
  assign scr_valid  = (count != '0);
  assign scr_addr   = scr_valid ? fifo_addr_mem[rd_ptr] : 13'h0000;
  assign scr_data   = scr_valid ? fifo_data_mem[rd_ptr] : 16'h0000;
  assign ovf_flag   = ovf_reg;
  assign fifo_count = count;

endmodule

// File: tb/tb_hack_data_bus.sv
// Directed, table-driven bench for hack_data_bus (FIFO_DEPTH = 4).
module tb_hack_data_bus;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic [14:0]   addressM;
  logic [15:0]   outM;
  logic          writeM;
  logic [15:0]   inM;
  logic          scr_valid;
  logic          scr_ready;
  logic [12:0]   scr_addr;
  logic [15:0]   scr_data;
  logic          kbd_valid;
  logic [15:0]   kbd_code;
  logic          ovf_flag;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;

  hack_data_bus #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .addressM   (addressM),
    .outM       (outM),
    .writeM     (writeM),
    .inM        (inM),
    .scr_valid  (scr_valid),
    .scr_ready  (scr_ready),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .kbd_valid  (kbd_valid),
    .kbd_code   (kbd_code),
    .ovf_flag   (ovf_flag),
    .fifo_count (fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for one cycle; expectations describe the state
  // observed during that cycle, before its rising edge commits anything.
  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic        we;
    logic        kv;
    logic [15:0] kc;
    logic        rdy;
    logic        chk_inm;
    logic [15:0] exp_inm;
    logic [2:0]  exp_cnt;
    logic        exp_ovf;
    logic        chk_head;
    logic [12:0] exp_saddr;
    logic [15:0] exp_sdata;
  } vec_t;

  vec_t vecs[$];
  int   n_part_a;

  task automatic add(input logic [14:0] addr, input logic [15:0] data, input logic we,
                     input logic kv, input logic [15:0] kc, input logic rdy,
                     input logic chk_inm, input logic [15:0] exp_inm,
                     input logic [2:0] exp_cnt, input logic exp_ovf,
                     input logic chk_head, input logic [12:0] exp_saddr,
                     input logic [15:0] exp_sdata);
    vec_t v;
    v.addr = addr; v.data = data; v.we = we; v.kv = kv; v.kc = kc; v.rdy = rdy;
    v.chk_inm = chk_inm; v.exp_inm = exp_inm; v.exp_cnt = exp_cnt; v.exp_ovf = exp_ovf;
    v.chk_head = chk_head; v.exp_saddr = exp_saddr; v.exp_sdata = exp_sdata;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [14:0] addr, input logic [15:0] data, input logic we,
                       input logic kv, input logic [15:0] kc, input logic rdy);
    addressM  = addr;
    outM      = data;
    writeM    = we;
    kbd_valid = kv;
    kbd_code  = kc;
    scr_ready = rdy;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    drive(v.addr, v.data, v.we, v.kv, v.kc, v.rdy);
    #1;
    check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(v.exp_cnt));
    check($sformatf("v%0d scr_valid", i), 32'(scr_valid), 32'(v.exp_cnt != 3'd0));
    check($sformatf("v%0d ovf_flag", i), 32'(ovf_flag), 32'(v.exp_ovf));
    if (v.chk_inm) check($sformatf("v%0d inM", i), 32'(inM), 32'(v.exp_inm));
    if (v.chk_head) begin
      check($sformatf("v%0d scr_addr", i), 32'(scr_addr), 32'(v.exp_saddr));
      check($sformatf("v%0d scr_data", i), 32'(scr_data), 32'(v.exp_sdata));
    end
  endtask

  initial begin
    // RAM write/read, read-during-write, unmapped
    add(15'h0010, 16'h1234, 1, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0);
    add(15'h0010, 16'h5555, 1, 0, 0, 0, 1, 16'h1234, 0, 0, 0, 0, 0);
    add(15'h0010, 16'h0000, 0, 0, 0, 0, 1, 16'h5555, 0, 0, 0, 0, 0);
    add(15'h0010, 16'h1234, 1, 0, 0, 0, 1, 16'h5555, 0, 0, 0, 0, 0);
    add(15'h0010, 16'h0000, 0, 0, 0, 0, 1, 16'h1234, 0, 0, 0, 0, 0);
    add(15'h6001, 16'hFFFF, 1, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
    add(15'h6001, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0);
    add(15'h7FFF, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
    // single screen write, then one-cycle drain
    add(15'h4005, 16'hAAAA, 1, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0);
    add(15'h4005, 16'h0000, 0, 0, 0, 0, 1, 16'hAAAA, 1, 0, 1, 13'h0005, 16'hAAAA);
    add(15'h4005, 16'h0000, 0, 0, 0, 1, 1, 16'hAAAA, 1, 0, 1, 13'h0005, 16'hAAAA);
    add(15'h4005, 16'h0000, 0, 0, 0, 0, 1, 16'hAAAA, 0, 0, 1, 0, 0);
    // five writes into a depth-4 queue: last one dropped, shadow still updated
    add(15'h4000, 16'd1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(15'h4001, 16'd2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'd1);
    add(15'h4002, 16'd3, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 16'd1);
    add(15'h4003, 16'd4, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0, 16'd1);
    add(15'h4004, 16'd5, 1, 0, 0, 0, 0, 0, 4, 0, 1, 0, 16'd1);
    add(15'h4004, 16'd0, 0, 0, 0, 0, 1, 16'd5, 4, 1, 1, 0, 16'd1);
    add(15'h4003, 16'd0, 0, 0, 0, 1, 1, 16'd4, 4, 1, 1, 0, 16'd1);
    add(15'h4000, 16'd0, 0, 0, 0, 1, 1, 16'd1, 3, 1, 1, 13'd1, 16'd2);
    add(15'h4000, 16'd0, 0, 0, 0, 1, 0, 0,     2, 1, 1, 13'd2, 16'd3);
    add(15'h4000, 16'd0, 0, 0, 0, 1, 0, 0,     1, 1, 1, 13'd3, 16'd4);
    add(15'h4000, 16'd0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 0, 0);
    n_part_a = vecs.size();
    // full queue with simultaneous pop and push
    add(15'h4010, 16'h0010, 1, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0);
    add(15'h4011, 16'h0011, 1, 0, 0, 0, 0, 0,        1, 0, 1, 13'h010, 16'h0010);
    add(15'h4012, 16'h0012, 1, 0, 0, 0, 0, 0,        2, 0, 1, 13'h010, 16'h0010);
    add(15'h4013, 16'h0013, 1, 0, 0, 0, 0, 0,        3, 0, 1, 13'h010, 16'h0010);
    add(15'h4014, 16'h0014, 1, 0, 0, 1, 0, 0,        4, 0, 1, 13'h010, 16'h0010);
    add(15'h4014, 16'h0000, 0, 0, 0, 0, 1, 16'h0014, 4, 0, 1, 13'h011, 16'h0011);
    add(15'h4014, 16'h0000, 0, 0, 0, 1, 0, 0,        4, 0, 1, 13'h011, 16'h0011);
    add(15'h4014, 16'h0000, 0, 0, 0, 1, 0, 0,        3, 0, 1, 13'h012, 16'h0012);
    add(15'h4014, 16'h0000, 0, 0, 0, 1, 0, 0,        2, 0, 1, 13'h013, 16'h0013);
    add(15'h4014, 16'h0000, 0, 0, 0, 1, 0, 0,        1, 0, 1, 13'h014, 16'h0014);
    add(15'h4014, 16'h0000, 0, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0);
    // keyboard strobes, same-cycle read sees old value, writes ignored
    add(15'h6000, 16'h0000, 0, 1, 16'h0041, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
    add(15'h6000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0041, 0, 0, 0, 0, 0);
    add(15'h6000, 16'h0000, 0, 1, 16'h0000, 0, 1, 16'h0041, 0, 0, 0, 0, 0);
    add(15'h6000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
    add(15'h6000, 16'h0000, 0, 1, 16'h0041, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
    add(15'h6000, 16'h1111, 1, 0, 16'h0000, 0, 1, 16'h0041, 0, 0, 0, 0, 0);
    add(15'h6000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0041, 0, 0, 1, 0, 0);
    add(15'h4005, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hAAAA, 0, 0, 0, 0, 0);

    // initial reset
    drive(15'h6000, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset scr_valid", 32'(scr_valid), 32'd0);
    check("reset ovf_flag", 32'(ovf_flag), 32'd0);
    check("reset scr_addr", 32'(scr_addr), 32'd0);
    check("reset scr_data", 32'(scr_data), 32'd0);
    check("reset kbd read", 32'(inM), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < n_part_a; i++) run_vec(i);

    // asynchronous reset mid-stream with 3 entries queued and overflow set
    @(negedge clk); drive(15'h4100, 16'h0100, 1, 1, 16'h00AB, 0);
    @(negedge clk); drive(15'h4101, 16'h0101, 1, 0, 16'h0000, 0);
    @(negedge clk); drive(15'h4102, 16'h0102, 1, 0, 16'h0000, 0);
    @(negedge clk); drive(15'h6000, 16'h0000, 0, 0, 16'h0000, 0);
    #1;
    check("pre-reset fifo_count", 32'(fifo_count), 32'd3);
    check("pre-reset ovf_flag", 32'(ovf_flag), 32'd1);
    check("pre-reset kbd", 32'(inM), 32'h00AB);
    check("pre-reset scr_addr", 32'(scr_addr), 32'h0100);
    #1;
    reset = 1'b1;
    #1;
    check("mid reset fifo_count", 32'(fifo_count), 32'd0);
    check("mid reset scr_valid", 32'(scr_valid), 32'd0);
    check("mid reset ovf_flag", 32'(ovf_flag), 32'd0);
    check("mid reset scr_addr", 32'(scr_addr), 32'd0);
    check("mid reset scr_data", 32'(scr_data), 32'd0);
    check("mid reset kbd", 32'(inM), 32'd0);
    addressM = 15'h0010;
    #1;
    check("mid reset ram kept", 32'(inM), 32'h1234);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post reset ram", 32'(inM), 32'h1234);
    addressM = 15'h4101;
    #1;
    check("post reset shadow", 32'(inM), 32'h0101);

    for (int i = n_part_a; i < vecs.size(); i++) run_vec(i);

    @(negedge clk);
    drive(15'h0000, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
